apb_timer_slave: RTL and testbench
==================================

Name: apb_timer_slave

Overview:
- Real APB timer peripheral that replaces the dummy slave on the Timer port (APB3, base 0x4003_0000) of the AXI4-Lite-to-APB bridge.
- Consumes the bridge's decoded psel/penable plus the shared paddr/pwrite/pwdata; returns prdata/pready to the bridge read mux.
- Provides a 32-bit prescaled down-counter with reload, one-shot/periodic modes and a level interrupt.

Parameters:
- WAIT_STATES, 1, number of ACCESS cycles with pready low before pready goes high (0 = zero-wait).
- PRESCALE_W, 16, width of the prescaler register and prescale counter.
- LOAD_RESET, 32'hFFFF_FFFF, reset value of LOAD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- paddr  input  32  APB address; only paddr[4:2] is decoded, paddr[1:0] is ignored.
- psel  input  1  slave select from the bridge decoder.
- penable  input  1  APB access phase.
- pwrite  input  1  1 = write.
- pwdata  input  32  write data.
- prdata  output  32  registered read data.
- pready  output  1  transfer complete.
- irq  output  1  level interrupt, = STATUS.EXP & CTRL.IRQ_EN.

Behaviour:
- Register map (offset: name):
  - 0x00 CTRL: [0] EN, [1] IRQ_EN, [2] ONESHOT; other bits read 0.
  - 0x04 LOAD: 32-bit reload value.
  - 0x08 VALUE: read-only current count; writes are ignored.
  - 0x0C PRESCALE: [PRESCALE_W-1:0]; upper bits read 0.
  - 0x10 STATUS: [0] EXP, write-1-to-clear.
  - Other offsets: read 0, writes ignored.
- Reset values: CTRL=0, LOAD=LOAD_RESET, VALUE=0, PRESCALE=0, STATUS=0, prescale counter=0, prdata=0, pready=0, irq=0, FSM=IDLE.
- APB FSM:
  - IDLE: on psel & !penable go to SETUP.
  - SETUP: go to ACCESS; load the wait counter with WAIT_STATES.
  - ACCESS: pready=0 while the wait counter is nonzero (decrement each cycle); when it is 0, drive pready=1 for exactly one cycle, then return to IDLE.
  - The register write commits and prdata is captured in the same cycle pready=1.
  - With WAIT_STATES=0, pready is high in the first ACCESS cycle.
- Protocol violations:
  - If psel drops in SETUP or ACCESS, return to IDLE with pready=0 and no register side effects.
  - psel & penable seen in IDLE is ignored.
- prdata holds its last captured value outside transfers and is never combinational from paddr.
- Counting (while CTRL.EN=1):
  - Tick: prescale counter increments each clk; when it equals PRESCALE it wraps to 0 and produces a tick. So the tick period is PRESCALE+1 clocks, and PRESCALE=0 ticks every clock.
  - On a tick with VALUE≠0: VALUE decrements by 1.
  - On a tick with VALUE==0: STATUS.EXP=1 and VALUE=LOAD. If ONESHOT=1, EN clears the same cycle.
  - LOAD=0 in periodic mode: EXP is set on every tick.
- Enable edge: a write that changes EN 0→1 loads VALUE=LOAD and clears the prescale counter. While EN=0 the counters hold.
- Writing LOAD while running does not change VALUE; the new value is used at the next reload.
- Simultaneous events:
  - STATUS W1C write in the same cycle as an expiry: set wins, EXP stays 1.
  - CTRL write clearing EN in the same cycle as a tick: EN=0 wins, and no decrement or expiry occurs.
- irq is combinational from registered bits (glitch-free); it deasserts the cycle after the W1C commit.
- Asynchronous reset mid-transfer: all state returns to reset values immediately; the bridge must restart the transfer.

Optional Feature:
- Macro APB_TIMER_PSLVERR_EN.
- Defined: adds output port pslverr (1 bit, reset 0). pslverr is asserted alongside pready for:
  - any access to an offset above 0x10;
  - a write to VALUE.
  In those cases there are no register side effects, and prdata=0 on reads.
- Not defined: no pslverr port; those accesses complete silently, as described in Behaviour.

Test Plan:
- Reset, then read all five registers (WAIT_STATES=1) → CTRL=0, LOAD=0xFFFF_FFFF, VALUE=0, PRESCALE=0, STATUS=0; each transfer has exactly one pready-low ACCESS cycle; irq=0.
- Write LOAD=5, PRESCALE=3, CTRL=0x3 → VALUE reads 5 right after enable; it decrements every 4 clocks; EXP and irq assert 24 clocks after the enable commit; VALUE reloads to 5; periodic repeat every 24 clocks.
- ONESHOT: LOAD=2, PRESCALE=0, CTRL=0x7 → expiry after 3 clocks; CTRL reads 0x6; VALUE holds 2; no second expiry within 100 clocks.
- W1C race: arrange a STATUS write of 0x1 committing on the same cycle as an expiry → EXP remains 1. A later write of 0x1 clears it, and irq falls the next cycle.
- Assert reset during the ACCESS phase of a CTRL write of 0x1 → pready=0 and all registers at reset values; the timer is not running after reset release.
- With APB_TIMER_PSLVERR_EN: read offset 0x20 → pready=1, pslverr=1, prdata=0; write 0x1234 to VALUE → pslverr=1 and VALUE unchanged. Without the macro, the same accesses give pslverr absent and no side effects.

Source files
------------

// File: rtl/apb_timer_slave.sv
// apb_timer_slave: APB3 timer peripheral on the bridge's Timer port.
// Prescaled 32-bit down-counter with reload, one-shot/periodic modes and a
// level interrupt. Optional macro APB_TIMER_PSLVERR_EN adds a pslverr output
// that flags unmapped offsets and writes to the read-only VALUE register.
module apb_timer_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned PRESCALE_W  = 16,
  parameter logic [31:0] LOAD_RESET  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] paddr,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        irq
`ifdef APB_TIMER_PSLVERR_EN
  ,
  output logic        pslverr
`endif
);

  localparam int unsigned WAIT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  localparam logic [2:0] IDX_CTRL     = 3'd0;
  localparam logic [2:0] IDX_LOAD     = 3'd1;
  localparam logic [2:0] IDX_VALUE    = 3'd2;
  localparam logic [2:0] IDX_PRESCALE = 3'd3;
  localparam logic [2:0] IDX_STATUS   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  pready_q, pready_d;
  logic [31:0]           prdata_q, prdata_d;
  logic                  en_q, en_d;
  logic                  irq_en_q, irq_en_d;
  logic                  oneshot_q, oneshot_d;
  logic [31:0]           load_q, load_d;
  logic [31:0]           value_q, value_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] psc_cnt_q, psc_cnt_d;
  logic                  exp_q, exp_d;

  logic        fire;
  logic [2:0]  reg_idx;
  logic        addr_err;
  logic        wr_ok;
  logic        ctrl_wr, load_wr, pre_wr, stat_wr;
  logic        tick, tick_eff, exp_set;
  logic [31:0] rdata_mux;

  assign reg_idx = paddr[4:2];

`ifdef APB_TIMER_PSLVERR_EN
  logic pslverr_q, pslverr_d;
  logic unused_paddr_bits;

  // Error when the offset lies above STATUS inside the 4 KB timer window, or on a VALUE write.
  assign addr_err = (reg_idx > IDX_STATUS) || (|paddr[11:5]) ||
                    (pwrite && (reg_idx == IDX_VALUE));
  assign unused_paddr_bits = ^{paddr[31:12], paddr[1:0]};
  assign pslverr = pslverr_q;
`else
  logic unused_paddr_bits;

  assign addr_err = 1'b0;
  assign unused_paddr_bits = ^{paddr[31:5], paddr[1:0]};
`endif

  assign prdata = prdata_q;
  assign pready = pready_q;
  // Level interrupt straight from flops, so it cannot glitch.
  assign irq    = exp_q & irq_en_q;

  // APB handshake: next state, wait counter and the single commit strobe.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    fire    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (psel && !penable) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACCESS;
          wait_d  = WAIT_W'(WAIT_STATES);
          fire    = (WAIT_STATES == 0);
        end
      end
      ST_ACCESS: begin
        if (pready_q || !psel) begin
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_W'(1)) begin
          wait_d = '0;
          fire   = 1'b1;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pready_d = fire;
  end

  // Read data mux over the register map.
  always_comb begin
    rdata_mux = '0;
    unique case (reg_idx)
      IDX_CTRL:     rdata_mux = {29'd0, oneshot_q, irq_en_q, en_q};
      IDX_LOAD:     rdata_mux = load_q;
      IDX_VALUE:    rdata_mux = value_q;
      IDX_PRESCALE: rdata_mux = 32'(prescale_q);
      IDX_STATUS:   rdata_mux = {31'd0, exp_q};
      default:      rdata_mux = '0;
    endcase
  end

  // Register writes, prescaler, down-counter and expiry handling.
  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    oneshot_d  = oneshot_q;
    load_d     = load_q;
    value_d    = value_q;
    prescale_d = prescale_q;
    psc_cnt_d  = psc_cnt_q;
    prdata_d   = prdata_q;
    exp_set    = 1'b0;

    wr_ok   = fire && pwrite && !addr_err;
    ctrl_wr = wr_ok && (reg_idx == IDX_CTRL);
    load_wr = wr_ok && (reg_idx == IDX_LOAD);
    pre_wr  = wr_ok && (reg_idx == IDX_PRESCALE);
    stat_wr = wr_ok && (reg_idx == IDX_STATUS);

    tick     = en_q && (psc_cnt_q == prescale_q);
    // A CTRL write that clears EN suppresses the tick landing in the same cycle.
    tick_eff = tick && !(ctrl_wr && !pwdata[0]);

    if (en_q) psc_cnt_d = tick ? '0 : psc_cnt_q + PRESCALE_W'(1);

    if (ctrl_wr) begin
      en_d      = pwdata[0];
      irq_en_d  = pwdata[1];
      oneshot_d = pwdata[2];
      if (pwdata[0] && !en_q) begin
        value_d   = load_q;
        psc_cnt_d = '0;
      end
    end
    if (load_wr) load_d = pwdata;
    if (pre_wr) prescale_d = pwdata[PRESCALE_W-1:0];

    if (tick_eff) begin
      if (value_q != '0) begin
        value_d = value_q - 32'd1;
      end else begin
        exp_set = 1'b1;
        value_d = load_q;
        if (oneshot_q) en_d = 1'b0;
      end
    end

    // Expiry set takes priority over a simultaneous write-1-to-clear.
    exp_d = exp_set || (exp_q && !(stat_wr && pwdata[0]));

    if (fire && !pwrite) prdata_d = addr_err ? 32'd0 : rdata_mux;
  end

`ifdef APB_TIMER_PSLVERR_EN
  // Error response accompanies the ready pulse.
  always_comb begin
    pslverr_d = fire && addr_err;
  end

  // Error flag register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pslverr_q <= 1'b0;
    else       pslverr_q <= pslverr_d;
  end
`endif

  // APB handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wait_q   <= '0;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
    end
  end

  // Timer register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      oneshot_q  <= 1'b0;
      load_q     <= LOAD_RESET;
      value_q    <= '0;
      prescale_q <= '0;
      psc_cnt_q  <= '0;
      exp_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      oneshot_q  <= oneshot_d;
      load_q     <= load_d;
      value_q    <= value_d;
      prescale_q <= prescale_d;
      psc_cnt_q  <= psc_cnt_d;
      exp_q      <= exp_d;
    end
  end

endmodule

// File: tb/tb_apb_timer_slave.sv
// tb_apb_timer_slave: scoreboard bench for apb_timer_slave (WAIT_STATES=1).
`timescale 1ns/1ps
module tb_apb_timer_slave;

  localparam int unsigned WS = 1;
  localparam logic [31:0] A_CTRL     = 32'h00;
  localparam logic [31:0] A_LOAD     = 32'h04;
  localparam logic [31:0] A_VALUE    = 32'h08;
  localparam logic [31:0] A_PRESCALE = 32'h0C;
  localparam logic [31:0] A_STATUS   = 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, irq;
`ifdef APB_TIMER_PSLVERR_EN
  logic        pslverr;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_commit;
  logic last_err;
  logic irq_at_ready;
  logic [31:0] sb_q[$];

  apb_timer_slave #(.WAIT_STATES(WS), .PRESCALE_W(16), .LOAD_RESET(32'hFFFF_FFFF)) dut (
    .clk     (clk),
    .reset   (reset),
    .paddr   (paddr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .irq     (irq)
`ifdef APB_TIMER_PSLVERR_EN
    ,
    .pslverr (pslverr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected VALUE after k edges since the enable commit, periodic mode.
  function automatic logic [31:0] tmodel(input int k, input logic [31:0] load, input int pre);
    int ticks;
    ticks = k / (pre + 1);
    return load - 32'(ticks % (int'(load) + 1));
  endfunction

  // One APB transfer starting at a negedge; ends after one idle cycle.
  task automatic apb_xfer(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [31:0] rd_exp);
    int c0;
    int lowcnt;
    bit done;
    logic [31:0] e;
    c0 = cyc;
    if (!wr) sb_q.push_back(rd_exp);
    psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = data;
    @(negedge clk);
    penable = 1'b1;
    lowcnt = 0;
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (pready) done = 1'b1;
      else lowcnt++;
    end
    last_commit  = cyc;
    irq_at_ready = irq;
`ifdef APB_TIMER_PSLVERR_EN
    last_err = pslverr;
`else
    last_err = 1'b0;
`endif
    chk({tag, "_rdy"}, 32'(done), 32'd1);
    if (done) begin
      chk({tag, "_wait"}, 32'(lowcnt), 32'(WS));
      chk({tag, "_lat"}, 32'(last_commit), 32'(c0 + 2 + int'(WS)));
    end
    if (!wr && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (done) chk(tag, prdata, e);
    end
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    apb_xfer(tag, 1'b0, addr, 32'd0, exp);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
    apb_xfer(tag, 1'b1, addr, data, 32'd0);
  endtask

  // VALUE read whose expectation comes from the periodic counter model.
  task automatic rd_val(input string tag, input int e, input logic [31:0] load, input int pre);
    int pred;
    pred = cyc + 2 + int'(WS);
    rd(tag, A_VALUE, tmodel(pred - 1 - e, load, pre));
  endtask

  task automatic wait_irq(input string tag, input int exp_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (irq) seen = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) chk(tag, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    int e;
    int d;
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_pready", 32'(pready), 32'd0);
    chk("rst_prdata", prdata, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Reset values of all registers.
    rd("r_ctrl", A_CTRL, 32'd0);
    rd("r_load", A_LOAD, 32'hFFFF_FFFF);
    rd("r_value", A_VALUE, 32'd0);
    rd("r_pre", A_PRESCALE, 32'd0);
    rd("r_stat", A_STATUS, 32'd0);
    chk("r_irq", 32'(irq), 32'd0);

    // Periodic mode: LOAD=5, PRESCALE=3 gives a 24-clock period.
    wr("p_load", A_LOAD, 32'd5);
    wr("p_pre", A_PRESCALE, 32'd3);
    wr("p_ctrl", A_CTRL, 32'h3);
    e = last_commit;
    rd_val("p_v0", e, 32'd5, 3);
    rd_val("p_v1", e, 32'd5, 3);
    rd_val("p_v2", e, 32'd5, 3);
    wait_irq("p_irq1", e + 24);
    rd_val("p_reload", e, 32'd5, 3);
    rd("p_stat", A_STATUS, 32'd1);
    rd_val("p_v3", e, 32'd5, 3);
    wr("p_w1c", A_STATUS, 32'd1);
    chk("p_irq_fall", 32'(irq_at_ready), 32'd0);
    wait_irq("p_irq2", e + 48);
    wr("p_dis", A_CTRL, 32'h0);
    wr("p_clr", A_STATUS, 32'd1);

    // One-shot: expiry after 3 clocks, EN self-clears, no second expiry.
    wr("o_load", A_LOAD, 32'd2);
    wr("o_pre", A_PRESCALE, 32'd0);
    wr("o_ctrl", A_CTRL, 32'h7);
    e = last_commit;
    wait_irq("o_irq", e + 3);
    rd("o_ctrl_rb", A_CTRL, 32'h6);
    rd("o_value", A_VALUE, 32'd2);
    wr("o_clr", A_STATUS, 32'd1);
    repeat (100) @(negedge clk);
    rd("o_stat", A_STATUS, 32'd0);
    rd("o_value2", A_VALUE, 32'd2);

    // W1C racing an expiry, then disable racing a tick.
    wr("w_load", A_LOAD, 32'd3);
    wr("w_ctrl", A_CTRL, 32'h3);
    e = last_commit;
    while (((cyc + 2 + int'(WS) - e) % 4 != 0) || ((cyc + 2 + int'(WS)) < e + 8))
      @(negedge clk);
    wr("w_race", A_STATUS, 32'd1);
    chk("w_set_wins", 32'(irq_at_ready), 32'd1);
    wr("w_dis", A_CTRL, 32'h2);
    d = last_commit;
    rd("w_hold", A_VALUE, tmodel(d - 1 - e, 32'd3, 0));
    chk("w_irq_pre", 32'(irq), 32'd1);
    wr("w_clr", A_STATUS, 32'd1);
    chk("w_irq_fall", 32'(irq_at_ready), 32'd0);
    repeat (5) @(negedge clk);
    rd("w_stat", A_STATUS, 32'd0);
    rd("w_load_rb", A_LOAD, 32'd3);

    // Reset in the ACCESS phase of a CTRL enable write.
    psel = 1'b1; penable = 1'b0; paddr = A_CTRL; pwrite = 1'b1; pwdata = 32'h1;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("x_pready", 32'(pready), 32'd0);
    chk("x_prdata", prdata, 32'd0);
    @(negedge clk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    rd("x_ctrl", A_CTRL, 32'd0);
    rd("x_load", A_LOAD, 32'hFFFF_FFFF);
    rd("x_pre", A_PRESCALE, 32'd0);
    repeat (20) @(negedge clk);
    rd("x_value", A_VALUE, 32'd0);
    rd("x_stat", A_STATUS, 32'd0);

    // Unmapped offsets and VALUE writes.
    rd("u_14", 32'h14, 32'd0);
`ifdef APB_TIMER_PSLVERR_EN
    chk("u_14_err", 32'(last_err), 32'd1);
`endif
    rd("u_20", 32'h20, 32'd0);
`ifdef APB_TIMER_PSLVERR_EN
    chk("u_20_err", 32'(last_err), 32'd1);
`endif
    wr("u_vwr", A_VALUE, 32'h1234);
`ifdef APB_TIMER_PSLVERR_EN
    chk("u_vwr_err", 32'(last_err), 32'd1);
`endif
    rd("u_value", A_VALUE, 32'd0);
`ifdef APB_TIMER_PSLVERR_EN
    chk("u_ok_err", 32'(last_err), 32'd0);
`endif
    rd("u_ctrl", A_CTRL, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
